// File: rtl/seg_scan_if.sv
// Display-side bundle for the seven-segment scan controller: value/strobe inputs,
// the loop out to the external hex decoder, and the registered display drive.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic [3:0]              nibble_out;
  logic [6:0]              seg_in;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    dp_out;
  logic                    frame_tick;

  modport master (
    output value_in, load, dp_in, lz_en, seg_in,
    input  nibble_out, seg_out, an_out, dp_out, frame_tick
  );

  modport slave (
    input  value_in, load, dp_in, lz_en, seg_in,
    output nibble_out, seg_out, an_out, dp_out, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with inter-digit blanking,
// leading-zero suppression, decimal points and frame-boundary value updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 1000,
  parameter int BLANK_CLKS     = 16
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);
  localparam int MAXC = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {BLANK, ON} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] disp, shadow;
  logic                    pending;
  logic                    boundary;
  logic                    upper_nz;
  logic                    suppress;
  logic [NUM_DIGITS-1:0]   an_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // The frame boundary is the final ON cycle of the last digit.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = idx;
    boundary = 1'b0;
    if (state == BLANK) begin
      if (cnt == CW'(BLANK_CLKS - 1)) begin
        state_nx = ON;
        cnt_nx   = '0;
      end
    end else begin
      if (cnt == CW'(CLKS_PER_DIGIT - 1)) begin
        state_nx = BLANK;
        cnt_nx   = '0;
        if (idx == IW'(NUM_DIGITS - 1)) begin
          idx_nx   = '0;
          boundary = 1'b1;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
    end
  end

  // Loads park in the shadow; disp only moves at the boundary so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (bus.load)
        disp <= bus.value_in;
      else if (pending)
        disp <= shadow;
      pending <= 1'b0;
    end else if (bus.load) begin
      shadow  <= bus.value_in;
      pending <= 1'b1;
    end
  end

  assign bus.nibble_out = disp[4*idx +: 4];
  assign an_sel         = ~(NUM_DIGITS'(1) << idx);

  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'h0)
        upper_nz = 1'b1;
    end
    suppress = bus.lz_en && (idx != '0) && !upper_nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an_out     <= '1;
      bus.seg_out    <= 7'h7F;
      bus.dp_out     <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= boundary;
      bus.an_out     <= '1;
      bus.seg_out    <= 7'h7F;
      bus.dp_out     <= 1'b1;
      if (state == ON) begin
        if (!suppress) begin
          bus.an_out  <= an_sel;
          bus.seg_out <= bus.seg_in;
          bus.dp_out  <= ~bus.dp_in[idx];
        end else if (bus.dp_in[idx]) begin
          bus.an_out <= an_sel;
          bus.dp_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 4 lit clocks, 2 blank clocks, 24-cycle frame)
// with a behavioural hex decoder closing the nibble/segment loop.
module tb_seg_scan_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   checkCount;
  int   failCount;

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .CLKS_PER_DIGIT(4),
    .BLANK_CLKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; state cycle k runs between edge k and edge k+1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign bus.seg_in = hex7(bus.nibble_out);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation at the negedge of cycle k shows outputs registered from state cycle k-1.
  task automatic gotoObs(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != k && guard < 2000);
    if (cyc != k) checkOutput("sync", cyc, k);
  endtask

  task automatic checkDisp(input int k, input string tag, input logic [3:0] an,
                           input logic [6:0] seg, input logic dp);
    gotoObs(k);
    checkOutput({tag, ".an"}, 32'(bus.an_out), 32'(an));
    checkOutput({tag, ".seg"}, 32'(bus.seg_out), 32'(seg));
    checkOutput({tag, ".dp"}, 32'(bus.dp_out), 32'(dp));
  endtask

  task automatic checkTick(input int k, input string tag, input logic exp);
    gotoObs(k);
    checkOutput(tag, 32'(bus.frame_tick), 32'(exp));
  endtask

  // Pulses load during state cycle k.
  task automatic applyStimulus(input int k, input logic [15:0] val);
    gotoObs(k);
    bus.value_in = val;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  initial begin
    checkCount   = 0;
    failCount    = 0;
    rst          = 1'b1;
    bus.value_in = '0;
    bus.load     = 1'b0;
    bus.dp_in    = '0;
    bus.lz_en    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.an", 32'(bus.an_out), 32'hF);
    checkOutput("rst.seg", 32'(bus.seg_out), 32'h7F);
    checkOutput("rst.dp", 32'(bus.dp_out), 32'h1);
    checkOutput("rst.tick", 32'(bus.frame_tick), 32'h0);
    checkOutput("rst.nib", 32'(bus.nibble_out), 32'h0);
    rst = 1'b0;

    // Default scan: frame 0 shows zeros, 1234 appears from frame 1
    checkTick(1, "tick.first", 1'b0);
    applyStimulus(2, 16'h1234);
    checkDisp(4, "f0.d0", 4'hE, 7'b1000000, 1'b1);
    checkDisp(10, "f0.d1.held", 4'hD, 7'b1000000, 1'b1);
    checkTick(23, "tick.pre", 1'b0);
    checkTick(24, "tick.f1", 1'b1);
    checkDisp(25, "f1.blank0", 4'hF, 7'h7F, 1'b1);
    checkDisp(27, "f1.d0.first", 4'hE, 7'b0011001, 1'b1);
    gotoObs(28);
    checkOutput("nib.d0", 32'(bus.nibble_out), 32'h4);
    checkDisp(30, "f1.d0.last", 4'hE, 7'b0011001, 1'b1);
    checkDisp(31, "f1.blank1a", 4'hF, 7'h7F, 1'b1);
    checkDisp(32, "f1.blank1b", 4'hF, 7'h7F, 1'b1);
    checkDisp(33, "f1.d1", 4'hD, 7'b0110000, 1'b1);
    checkDisp(40, "f1.d2", 4'hB, 7'b0100100, 1'b1);
    checkDisp(46, "f1.d3", 4'h7, 7'b1111001, 1'b1);
    checkTick(48, "tick.f2", 1'b1);

    // Leading-zero suppression on 0050, then on 0000
    bus.lz_en = 1'b1;
    applyStimulus(50, 16'h0050);
    checkDisp(76, "lz.d0", 4'hE, 7'b1000000, 1'b1);
    checkDisp(82, "lz.d1", 4'hD, 7'b0010010, 1'b1);
    checkDisp(88, "lz.d2", 4'hF, 7'h7F, 1'b1);
    checkDisp(94, "lz.d3", 4'hF, 7'h7F, 1'b1);
    applyStimulus(96, 16'h0000);
    checkDisp(124, "lz0.d0", 4'hE, 7'b1000000, 1'b1);
    checkDisp(130, "lz0.d1", 4'hF, 7'h7F, 1'b1);
    checkDisp(142, "lz0.d3", 4'hF, 7'h7F, 1'b1);

    // Decimal point on a suppressed digit
    bus.dp_in = 4'b0100;
    applyStimulus(144, 16'h0007);
    checkDisp(172, "dp.d0", 4'hE, 7'b1111000, 1'b1);
    checkDisp(184, "dp.d2", 4'hB, 7'h7F, 1'b0);
    checkDisp(190, "dp.d3", 4'hF, 7'h7F, 1'b1);
    gotoObs(192);
    bus.dp_in = 4'b0000;
    bus.lz_en = 1'b0;

    // Mid-frame load held until the boundary
    applyStimulus(200, 16'hAAAA);
    checkDisp(214, "tear.d3.old", 4'h7, 7'b1000000, 1'b1);
    checkTick(216, "tear.tick", 1'b1);
    checkTick(217, "tear.tick.off", 1'b0);
    checkDisp(220, "tear.d0.new", 4'hE, 7'b0001000, 1'b1);
    checkDisp(238, "tear.d3.new", 4'h7, 7'b0001000, 1'b1);

    // Load on the boundary cycle bypasses straight into the next frame
    applyStimulus(239, 16'h9876);
    checkDisp(244, "bnd.d0", 4'hE, 7'b0000010, 1'b1);

    // Back-to-back loads: last one wins
    applyStimulus(250, 16'h1111);
    applyStimulus(254, 16'h2222);
    checkDisp(262, "b2b.d3.old", 4'h7, 7'b0010000, 1'b1);
    checkDisp(268, "b2b.d0", 4'hE, 7'b0100100, 1'b1);
    checkDisp(280, "b2b.d2", 4'hB, 7'b0100100, 1'b1);

    // Asynchronous reset during the digit-2 ON slot
    checkDisp(303, "pre.rst.d2", 4'hB, 7'b0100100, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid.rst.an", 32'(bus.an_out), 32'hF);
    checkOutput("mid.rst.seg", 32'(bus.seg_out), 32'h7F);
    checkOutput("mid.rst.dp", 32'(bus.dp_out), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkDisp(1, "post.blank0", 4'hF, 7'h7F, 1'b1);
    checkDisp(4, "post.d0", 4'hE, 7'b1000000, 1'b1);
    checkDisp(22, "post.d3", 4'h7, 7'b1000000, 1'b1);
    checkTick(24, "post.tick", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
